// File: rtl/seg_serial_driver.sv
// seg_serial_driver
//   Builds a DIGITS-byte active-low segment frame and shifts it MSB first into
//   a 74HC164-style segment shift chain, then pulses seg_latch to transfer the
//   chain to the segment outputs.
//
//   Text mode (mode=0): each digit byte is {point_n[d], hex7(nibble d)}, or
//   0xFF when blank[d] is set. Graphic mode (mode=1): each digit byte is the
//   raw disp_num byte. Segment byte layout is {dp,g,f,e,d,c,b,a}, 0 = lit.
//
//   Parameters:
//     DIGITS   number of 7-segment digits (frame length N = DIGITS*8)
//     CLK_DIV  clk cycles per seg_clk phase (>= 1)
//
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     start      request a frame transfer (sampled only when idle)
//     mode       0 = text (hex), 1 = graphic (raw)
//     disp_num   digit data, DIGITS*8 bits
//     point_n    text mode: 0 lights dp of digit d
//     blank      text mode: 1 blanks digit d
//     seg_clk    shift clock to the chain
//     seg_sout   serial data to the chain
//     seg_latch  transfer pulse after the last bit
//     seg_clrn   active-low chain clear (low while rst is high)
//     busy       high while a frame is in flight
//     done       one-cycle pulse at the end of a frame
//
//   Optional build macro: SEG_AUTO_REFRESH_EN
//     When defined, a shadow copy of the last transmitted frame is kept and a
//     transfer starts automatically whenever the computed frame differs from it.

module seg_serial_driver #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DIGITS*8-1:0]   disp_num,
  input  logic [DIGITS-1:0]     point_n,
  input  logic [DIGITS-1:0]     blank,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_latch,
  output logic                  seg_clrn,
  output logic                  busy,
  output logic                  done
);

  localparam int N     = DIGITS * 8;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [N-1:0]      sr;
  logic [N-1:0]      sr_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_next;
  logic [PH_W-1:0]   phase_cnt;
  logic              phase_last;
  logic              trigger;
  logic              capture;
  logic              shift_now;
  logic [N-1:0]      frame;

  logic seg_clk_d;
  logic seg_sout_d;
  logic seg_latch_d;
  logic busy_d;
  logic done_d;

  // Active-low hex glyphs for segments g..a; dp is supplied separately.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Frame as it would be captured this cycle. In text mode only the low
  // DIGITS*4 bits of disp_num are consulted.
  always_comb begin
    frame = '1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (mode) begin
        frame[8*d +: 8] = disp_num[8*d +: 8];
      end else if (!blank[d]) begin
        frame[8*d +: 8] = {point_n[d], hex7(disp_num[4*d +: 4])};
      end
    end
  end

`ifdef SEG_AUTO_REFRESH_EN
  logic [N-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '1;
    end else if (capture) begin
      shadow <= frame;
    end
  end

  always_comb begin
    trigger = start || (frame != shadow);
  end
`else
  always_comb begin
    trigger = start;
  end
`endif

  assign phase_last = (phase_cnt == PH_LAST);
  assign capture    = (state == IDLE) && trigger;
  assign shift_now  = (state == SHIFT_HI) && phase_last;

  // State register together with the frame datapath it sequences.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '1;
      bit_cnt   <= '0;
      phase_cnt <= '0;
    end else begin
      state   <= next_state;
      sr      <= sr_next;
      bit_cnt <= bit_cnt_next;
      if ((next_state != state) || (state == IDLE) || (state == DONE)) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (trigger) next_state = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (phase_last) next_state = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_last) next_state = (bit_cnt == LAST_BIT) ? LATCH : SHIFT_LO;
      end
      LATCH: begin
        if (phase_last) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath next values: load on capture, shift one bit per completed
  // high phase (chain has already sampled on the rising seg_clk edge).
  always_comb begin
    sr_next      = sr;
    bit_cnt_next = bit_cnt;
    if (capture) begin
      sr_next      = frame;
      bit_cnt_next = '0;
    end else if (shift_now) begin
      sr_next      = {sr[N-2:0], 1'b1};
      bit_cnt_next = bit_cnt + 1'b1;
    end
  end

  // Output decode is taken from the next state and next shift register so
  // that every registered output lines up with the state it belongs to.
  always_comb begin
    seg_clk_d   = (next_state == SHIFT_HI);
    seg_sout_d  = ((next_state == SHIFT_LO) || (next_state == SHIFT_HI)) ? sr_next[N-1] : 1'b1;
    seg_latch_d = (next_state == LATCH);
    busy_d      = (next_state != IDLE);
    done_d      = (next_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_clk   <= 1'b0;
      seg_sout  <= 1'b1;
      seg_latch <= 1'b0;
      seg_clrn  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      seg_clk   <= seg_clk_d;
      seg_sout  <= seg_sout_d;
      seg_latch <= seg_latch_d;
      seg_clrn  <= 1'b1;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Testbench for seg_serial_driver. Lane 0 runs CLK_DIV=1, lane 1 runs
// CLK_DIV=3; both share data inputs and reset but have separate start lines.
module tb_seg_serial_driver;

  localparam int DIGITS = 8;
  localparam int N      = DIGITS * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start = 2'b00;
  logic        mode = 1'b0;
  logic [63:0] disp_num = '0;
  logic [7:0]  point_n = 8'hFF;
  logic [7:0]  blank = 8'h00;
  logic        mon_clr = 1'b1;

  logic [1:0]  seg_clk, seg_sout, seg_latch, seg_clrn, busy, done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int K = (g == 0) ? 1 : 3;

    seg_serial_driver #(.DIGITS(DIGITS), .CLK_DIV(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
      .mode      (mode),
      .disp_num  (disp_num),
      .point_n   (point_n),
      .blank     (blank),
      .seg_clk   (seg_clk[g]),
      .seg_sout  (seg_sout[g]),
      .seg_latch (seg_latch[g]),
      .seg_clrn  (seg_clrn[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );

    int          busy_cnt, latch_cnt, done_cnt, bits, phase_err, stab_err, run;
    logic [63:0] rx, frame0, frame1;
    logic        prev_clk, prev_sout, seen_rise;

    always @(negedge clk) begin
      if (mon_clr) begin
        busy_cnt <= 0; latch_cnt <= 0; done_cnt <= 0; bits <= 0;
        phase_err <= 0; stab_err <= 0; run <= 0; seen_rise <= 1'b0;
        rx <= '0; frame0 <= '0; frame1 <= '0;
      end else begin
        if (busy[g]) busy_cnt <= busy_cnt + 1;
        if (seg_latch[g]) latch_cnt <= latch_cnt + 1;
        if (done[g]) begin
          done_cnt <= done_cnt + 1;
          if (done_cnt == 0) frame0 <= rx;
          else if (done_cnt == 1) frame1 <= rx;
        end
        if (seg_clk[g] && !prev_clk) begin
          rx   <= {rx[62:0], seg_sout[g]};
          bits <= bits + 1;
          if (seg_sout[g] !== prev_sout) stab_err <= stab_err + 1;
          if (seen_rise && run != K) phase_err <= phase_err + 1;
          seen_rise <= 1'b1;
        end
        if (!seg_clk[g] && prev_clk && busy[g] && run != K) phase_err <= phase_err + 1;
        if (seg_clk[g] == prev_clk) run <= run + 1;
        else run <= 1;
        if (!busy[g]) seen_rise <= 1'b0;
      end
      prev_clk  <= seg_clk[g];
      prev_sout <= seg_sout[g];
    end
  end

  typedef struct {
    logic        mode;
    logic [63:0] dn;
    logic [7:0]  pn;
    logic [7:0]  bl;
    logic [63:0] exp;
  } vec_t;

  vec_t tab [12];

  // Reference frame straight from the digit rules.
  function automatic logic [63:0] ref_frame(input logic m, input logic [63:0] dn,
                                            input logic [7:0] pn, input logic [7:0] bl);
    logic [63:0] f;
    logic [7:0]  b;
    for (int d = 0; d < DIGITS; d++) begin
      if (m) b = dn[8*d +: 8];
      else if (bl[d]) b = 8'hFF;
      else b = {pn[d], hex_tab[dn[4*d +: 4]][6:0]};
      f[8*d +: 8] = b;
    end
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic snap(input int ln, output int bc, output int lc, output int dc, output int nb,
                      output int pe, output int se, output logic [63:0] f0, output logic [63:0] f1);
    if (ln == 0) begin
      bc = lane[0].busy_cnt; lc = lane[0].latch_cnt; dc = lane[0].done_cnt; nb = lane[0].bits;
      pe = lane[0].phase_err; se = lane[0].stab_err; f0 = lane[0].frame0; f1 = lane[0].frame1;
    end else begin
      bc = lane[1].busy_cnt; lc = lane[1].latch_cnt; dc = lane[1].done_cnt; nb = lane[1].bits;
      pe = lane[1].phase_err; se = lane[1].stab_err; f0 = lane[1].frame0; f1 = lane[1].frame1;
    end
  endtask

  task automatic apply(input vec_t v);
    mode = v.mode; disp_num = v.dn; point_n = v.pn; blank = v.bl;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic run_frame(input int ln, input vec_t v, input string name);
    int bc, lc, dc, nb, pe, se, k;
    logic [63:0] f0, f1;
    k = (ln == 0) ? 1 : 3;
    apply(v);
    clear_mon();
    start[ln] = 1'b1;
    @(posedge clk); #1;
    start[ln] = 1'b0;
    dc = 0;
    for (int i = 0; i < 1000; i++) begin
      snap(ln, bc, lc, dc, nb, pe, se, f0, f1);
      if (dc != 0) break;
      @(posedge clk); #1;
    end
    chk({name, "/timeout"}, 64'(dc != 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    snap(ln, bc, lc, dc, nb, pe, se, f0, f1);
    chk({name, "/frame"}, f0, v.exp);
    chk({name, "/bits"}, 64'(nb), 64'(N));
    chk({name, "/busy_len"}, 64'(bc), 64'(2 * k * N + k + 1));
    chk({name, "/latch_len"}, 64'(lc), 64'(k));
    chk({name, "/done_cnt"}, 64'(dc), 64'd1);
    chk({name, "/phase"}, 64'(pe), 64'd0);
    chk({name, "/sout_stable"}, 64'(se), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int bc, lc, dc, nb, pe, se, nd;
    logic [63:0] f0, f1, new_dn, exp_b;
    bit chg;

    tab[0] = '{1'b0, 64'h0000_0000_1234_5678, 8'hFF, 8'h00, 64'hF9A4_B099_9282_F880};
    tab[1] = '{1'b0, 64'h0000_0000_0000_ABCD, 8'hFE, 8'hF0, 64'hFFFF_FFFF_8883_C621};
    tab[2] = '{1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 8'h00, 64'h0123_4567_89AB_CDEF};
    for (int i = 3; i < 12; i++) begin
      tab[i].mode = (i < 8) ? 1'b0 : 1'b1;
      tab[i].dn   = {$urandom(), $urandom()};
      tab[i].pn   = 8'($urandom());
      tab[i].bl   = (i == 3) ? 8'h00 : 8'($urandom());
      tab[i].exp  = ref_frame(tab[i].mode, tab[i].dn, tab[i].pn, tab[i].bl);
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst/seg_clk", 64'(seg_clk), 64'h0);
    chk("rst/seg_sout", 64'(seg_sout), 64'h3);
    chk("rst/seg_latch", 64'(seg_latch), 64'h0);
    chk("rst/seg_clrn", 64'(seg_clrn), 64'h0);
    chk("rst/busy", 64'(busy), 64'h0);
    chk("rst/done", 64'(done), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst/seg_clrn", 64'(seg_clrn), 64'h3);
    chk("post_rst/busy", 64'(busy), 64'h0);
    mon_clr = 1'b0;

    for (int i = 0; i < 12; i++) run_frame(0, tab[i], $sformatf("vec%0d", i));

    run_frame(1, tab[0], "div3_text");
    run_frame(1, tab[2], "div3_graphic");

    // Reset in the middle of a frame
    apply(tab[1]);
    clear_mon();
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    nb = 0;
    for (int i = 0; i < 500 && nb < 20; i++) begin
      @(negedge clk);
      nb = lane[0].bits;
    end
    chk("midrst/reach_bit20", 64'(nb >= 20), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst/busy", 64'(busy[0]), 64'h0);
    chk("midrst/seg_clrn", 64'(seg_clrn[0]), 64'h0);
    chk("midrst/seg_clk", 64'(seg_clk[0]), 64'h0);
    chk("midrst/done", 64'(done[0]), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    snap(0, bc, lc, dc, nb, pe, se, f0, f1);
    chk("midrst/no_done", 64'(dc), 64'd0);
    chk("midrst/no_latch", 64'(lc), 64'd0);
    chk("midrst/clrn_after", 64'(seg_clrn[0]), 64'h1);
    run_frame(0, tab[0], "after_midrst");

    // start held high, data changed mid-frame
    apply(tab[0]);
    new_dn = 64'hFEDC_BA98_7654_3210;
    exp_b  = ref_frame(1'b0, new_dn, 8'hFF, 8'h00);
    clear_mon();
    start[0] = 1'b1;
    nd  = 0;
    chg = 1'b0;
    for (int i = 0; i < 1500 && nd < 2; i++) begin
      @(negedge clk);
      if (!chg && lane[0].bits >= 10) begin
        disp_num = new_dn;
        chg = 1'b1;
      end
      if (done[0]) begin
        nd++;
        if (nd == 1) begin
          @(negedge clk);
          chk("held/gap_idle", 64'(busy[0]), 64'h0);
          @(negedge clk);
          chk("held/retrigger", 64'(busy[0]), 64'h1);
        end
      end
    end
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("held/two_frames_seen", 64'(nd), 64'd2);
    repeat (5) @(posedge clk);
    #1;
    snap(0, bc, lc, dc, nb, pe, se, f0, f1);
    chk("held/done_cnt", 64'(dc), 64'd2);
    chk("held/frame_first", f0, tab[0].exp);
    chk("held/frame_second", f1, exp_b);
    chk("held/no_third", 64'(busy[0]), 64'h0);

    // Input change without start
    clear_mon();
    disp_num = 64'h0000_0000_0BAD_F00D;
    repeat (300) @(posedge clk);
    #1;
    snap(0, bc, lc, dc, nb, pe, se, f0, f1);
`ifdef SEG_AUTO_REFRESH_EN
    chk("auto/one_transfer", 64'(dc), 64'd1);
    chk("auto/frame", f0, ref_frame(mode, disp_num, point_n, blank));
`else
    chk("nostart/no_transfer", 64'(dc), 64'd0);
`endif
    repeat (300) @(posedge clk);
    #1;
    snap(0, bc, lc, nb, nd, pe, se, f0, f1);
`ifdef SEG_AUTO_REFRESH_EN
    chk("auto/unchanged_idle", 64'(lc), 64'd1);
`else
    chk("nostart/still_idle", 64'(lc), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
